patbuf_ctrl: RTL and testbench
==============================

Name: patbuf_ctrl

Overview:
- Controller in front of the pattern buffer (addressed {bufp, field pointer}, one read port, one write port).
- Shares the single write port between the PAT core and a host burst loader.
- Sequences host bursts into a non-active buffer with auto-incrementing, wrapping field addresses.
- Read port always belongs to the core; the block sits between pat, patternbuffer and the host load interface in digital.

Parameters:
d_width, 8, data width of one field
bufp_width, 3, buffer select width
fieldp_width, 5, field pointer width (32 fields per buffer)
starve_max, 4, consecutive denied host cycles before the host is forced through (1..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
core_bufp  input  bufp_width  buffer currently used by core
core_fieldp  input  fieldp_width  core read field
core_fieldwp  input  fieldp_width  core write field
core_wen  input  1  core write request
core_wdata  input  d_width  core write data
core_rdata  output  d_width  read data to core
core_stall  output  1  core write not performed this cycle; core must hold it
pb_rd_adr  output  bufp_width+fieldp_width  buffer read address
pb_wr_adr  output  bufp_width+fieldp_width  buffer write address
pb_wen  output  1  buffer write enable
pb_wdata  output  d_width  buffer write data
pb_rdata  input  d_width  buffer read data
ld_start  input  1  start burst (1-cycle)
ld_buf  input  bufp_width  target buffer
ld_base  input  fieldp_width  first field
ld_len  input  fieldp_width+1  field count, 1..2^fieldp_width
ld_valid  input  1  host data valid
ld_data  input  d_width  host data
ld_ready  output  1  host beat accepted this cycle
ld_busy  output  1  burst in progress
ld_done  output  1  1-cycle pulse, last beat written
ld_err  output  1  1-cycle pulse, start rejected

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; counters 0; ld_ready, ld_busy, ld_done, ld_err, core_stall, pb_wen = 0. Reset mid-burst aborts the burst with no ld_done; already written fields stay written.
- Read path is combinational: pb_rd_adr = {core_bufp, core_fieldp}; core_rdata = pb_rdata.
- States: IDLE, LOAD.
- IDLE, ld_start: rejected with ld_err pulse next cycle when ld_len==0, ld_len>2^fieldp_width, or ld_buf==core_bufp. Otherwise latch buf/base/len, set beat counter to 0, go to LOAD; ld_busy=1 from next cycle.
- In LOAD, ld_start is ignored and pulses ld_err.
- LOAD, per cycle with ld_valid=1, write-port arbitration (combinational):
  - core_wen=0: host wins.
  - core_wen=1 and starve counter < starve_max: core wins; starve counter increments.
  - core_wen=1 and starve counter == starve_max: host wins; core_stall=1 that cycle.
- Host win: pb_wen=1, pb_wr_adr = {ld_buf_q, (base+beat) mod 2^fieldp_width}, pb_wdata=ld_data, ld_ready=1, beat counter increments, starve counter clears.
- Core win or no host beat: pb_wr_adr = {core_bufp, core_fieldwp}, pb_wen=core_wen, pb_wdata=core_wdata, core_stall=0.
- ld_valid=0 does not change the starve counter.
- Last beat accepted: ld_done pulses next cycle; ld_busy falls and state returns to IDLE on the same edge.
- Field address wraps modulo 2^fieldp_width inside the target buffer and never carries into bufp.
- If the core switches core_bufp to the loading buffer mid-burst, the load continues; it is not checked after start.
- Outside LOAD, core_stall=0 and the write port is pure pass-through.

Optional Feature:
- PATBUF_LD_CSUM_EN defined: adds output ld_csum [d_width-1:0].
  - Cleared on accepted start.
  - On each accepted beat: ld_csum += ld_data, mod 2^d_width.
  - Valid and stable from ld_done until the next accepted start.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package patbuf_pkg: state enum (IDLE, LOAD), default widths, and a function computing the wrapped field address.
- One natural sub-module, patbuf_wr_arb: pure write-port arbitration mux plus the starve counter. FSM and beat counter stay in patbuf_ctrl.

Test Plan:
- Reset low 2 cycles mid-burst: all outputs 0, state IDLE, no ld_done.
- core_bufp=0, start ld_buf=1, base=30, len=4, ld_valid held high, core_wen=0: writes at adr 0x3E, 0x3F, 0x20, 0x21 with host data; ld_done one cycle after the 4th beat.
- ld_buf==core_bufp=2: ld_err pulse, ld_busy stays 0, no pb_wen from host. Repeat with len=0 and len=33: same response.
- starve_max=4, core_wen=1 every cycle, ld_valid=1: 4 core writes, then 1 host write with core_stall=1; pattern repeats every 5 cycles until done.
- ld_start during LOAD: ld_err pulse; the in-flight burst completes unchanged.
- With PATBUF_LD_CSUM_EN, load bytes 0xF0, 0x20, 0x05: ld_csum=0x15 at ld_done.

Source files
------------

// File: rtl/patbuf_pkg.sv
// Shared types and helpers for the pattern-buffer controller.
// Contents:
//   state_e      controller state (IDLE, LOAD)
//   *_DEF        default widths / limits used as parameter defaults
//   STARVE_W     width of the host starvation counter (holds 0..15)
//   wrap_field   field address of a burst beat, wrapped inside one buffer
package patbuf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  localparam int unsigned D_WIDTH_DEF      = 8;
  localparam int unsigned BUFP_WIDTH_DEF   = 3;
  localparam int unsigned FIELDP_WIDTH_DEF = 5;
  localparam int unsigned STARVE_MAX_DEF   = 4;
  localparam int unsigned STARVE_W         = 4;

  // The mask keeps the carry out of the field pointer so a burst never
  // spills into the neighbouring buffer.
  function automatic int unsigned wrap_field(input int unsigned base,
                                             input int unsigned beat,
                                             input int unsigned fw);
    return (base + beat) & ((32'd1 << fw) - 32'd1);
  endfunction

endpackage

// File: rtl/patbuf_wr_arb.sv
// Write-port arbiter for the pattern buffer.
// Chooses between a core write and a host burst beat each cycle and keeps
// the starvation counter that eventually forces the host through.
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   host_req               host beat pending (LOAD and ld_valid)
//   host_adr, host_data    host write address / data
//   core_wen, core_adr,
//   core_wdata             core write request / address / data
//   host_win               host beat written this cycle (ld_ready)
//   core_stall             core write blocked this cycle
//   pb_wen, pb_wr_adr,
//   pb_wdata               buffer write port
module patbuf_wr_arb
  import patbuf_pkg::*;
#(
  parameter int unsigned d_width    = D_WIDTH_DEF,
  parameter int unsigned adr_width  = BUFP_WIDTH_DEF + FIELDP_WIDTH_DEF,
  parameter int unsigned starve_max = STARVE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_req,
  input  logic [adr_width-1:0] host_adr,
  input  logic [d_width-1:0]   host_data,
  input  logic                 core_wen,
  input  logic [adr_width-1:0] core_adr,
  input  logic [d_width-1:0]   core_wdata,
  output logic                 host_win,
  output logic                 core_stall,
  output logic                 pb_wen,
  output logic [adr_width-1:0] pb_wr_adr,
  output logic [d_width-1:0]   pb_wdata
);

  logic [STARVE_W-1:0] starve_q;

  always_comb begin
    host_win   = host_req && (!core_wen || (starve_q >= STARVE_W'(starve_max)));
    core_stall = host_win && core_wen;
    pb_wen     = core_wen;
    pb_wr_adr  = core_adr;
    pb_wdata   = core_wdata;
    if (host_win) begin
      pb_wen    = 1'b1;
      pb_wr_adr = host_adr;
      pb_wdata  = host_data;
    end
  end

  // Counts host beats lost to the core; idle host cycles leave it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (host_win) begin
      starve_q <= '0;
    end else if (host_req && core_wen) begin
      starve_q <= starve_q + 1'b1;
    end
  end

endmodule

// File: rtl/patbuf_ctrl.sv
// Pattern-buffer controller: shares the buffer write port between the PAT
// core and a host burst loader; the read port belongs to the core.
// Build option: PATBUF_LD_CSUM_EN adds ld_csum, the byte sum of the burst.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   core_bufp/fieldp/fieldwp        core buffer, read field, write field
//   core_wen/wdata, core_rdata      core write request/data, read data
//   core_stall                      core write held off this cycle
//   pb_rd_adr/pb_rdata              buffer read port
//   pb_wr_adr/pb_wen/pb_wdata       buffer write port
//   ld_start/buf/base/len           burst request
//   ld_valid/data, ld_ready         host beat handshake
//   ld_busy, ld_done, ld_err        burst status
//   ld_csum (optional)              sum of accepted beats mod 2^d_width
module patbuf_ctrl
  import patbuf_pkg::*;
#(
  parameter int unsigned d_width      = D_WIDTH_DEF,
  parameter int unsigned bufp_width   = BUFP_WIDTH_DEF,
  parameter int unsigned fieldp_width = FIELDP_WIDTH_DEF,
  parameter int unsigned starve_max   = STARVE_MAX_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [bufp_width-1:0]            core_bufp,
  input  logic [fieldp_width-1:0]          core_fieldp,
  input  logic [fieldp_width-1:0]          core_fieldwp,
  input  logic                             core_wen,
  input  logic [d_width-1:0]               core_wdata,
  output logic [d_width-1:0]               core_rdata,
  output logic                             core_stall,
  output logic [bufp_width+fieldp_width-1:0] pb_rd_adr,
  output logic [bufp_width+fieldp_width-1:0] pb_wr_adr,
  output logic                             pb_wen,
  output logic [d_width-1:0]               pb_wdata,
  input  logic [d_width-1:0]               pb_rdata,
  input  logic                             ld_start,
  input  logic [bufp_width-1:0]            ld_buf,
  input  logic [fieldp_width-1:0]          ld_base,
  input  logic [fieldp_width:0]            ld_len,
  input  logic                             ld_valid,
  input  logic [d_width-1:0]               ld_data,
  output logic                             ld_ready,
  output logic                             ld_busy,
  output logic                             ld_done,
  output logic                             ld_err
`ifdef PATBUF_LD_CSUM_EN
  ,
  output logic [d_width-1:0]               ld_csum
`endif
);

  localparam int unsigned ADR_W  = bufp_width + fieldp_width;
  localparam int unsigned NFIELD = 1 << fieldp_width;

  state_e                  state_q, state_d;
  logic [bufp_width-1:0]   buf_q;
  logic [fieldp_width-1:0] base_q;
  logic [fieldp_width:0]   len_q;
  logic [fieldp_width:0]   beat_q;
  logic                    done_q, err_q;
  logic                    start_ok, start_acc, host_req, host_win, last_beat;
  logic [fieldp_width-1:0] host_field;
  logic [ADR_W-1:0]        host_adr;

  assign pb_rd_adr  = {core_bufp, core_fieldp};
  assign core_rdata = pb_rdata;

  // The loading buffer is only compared with the core's buffer at start.
  assign start_ok  = (ld_len != '0) && (ld_len <= (fieldp_width+1)'(NFIELD)) &&
                     (ld_buf != core_bufp);
  assign start_acc = (state_q == IDLE) && ld_start && start_ok;
  assign host_req  = (state_q == LOAD) && ld_valid;
  assign last_beat = host_win && (beat_q == len_q - 1'b1);

  assign host_field = fieldp_width'(wrap_field(32'(base_q), 32'(beat_q), fieldp_width));
  assign host_adr   = {buf_q, host_field};

  assign ld_busy  = (state_q == LOAD);
  assign ld_ready = host_win;
  assign ld_done  = done_q;
  assign ld_err   = err_q;

  patbuf_wr_arb #(
    .d_width    (d_width),
    .adr_width  (ADR_W),
    .starve_max (starve_max)
  ) u_wr_arb (
    .clk        (clk),
    .reset      (reset),
    .host_req   (host_req),
    .host_adr   (host_adr),
    .host_data  (ld_data),
    .core_wen   (core_wen),
    .core_adr   ({core_bufp, core_fieldwp}),
    .core_wdata (core_wdata),
    .host_win   (host_win),
    .core_stall (core_stall),
    .pb_wen     (pb_wen),
    .pb_wr_adr  (pb_wr_adr),
    .pb_wdata   (pb_wdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = LOAD;
      LOAD:    if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_beat;
      err_q   <= ld_start && ((state_q == LOAD) || !start_ok);
      if (start_acc) begin
        beat_q <= '0;
      end else if (host_win) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Burst descriptor: only meaningful while LOAD, so it carries no reset.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      buf_q  <= ld_buf;
      base_q <= ld_base;
      len_q  <= ld_len;
    end
  end

`ifdef PATBUF_LD_CSUM_EN
  logic [d_width-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (start_acc) begin
      csum_q <= '0;
    end else if (host_win) begin
      csum_q <= csum_q + ld_data;
    end
  end

  assign ld_csum = csum_q;
`endif

endmodule

// File: tb/tb_patbuf_ctrl.sv
// Directed bench for patbuf_ctrl: reset, read path, wrapping burst,
// rejected starts, starvation arbitration, start during LOAD, reset
// mid-burst and (when PATBUF_LD_CSUM_EN is defined) the burst checksum.
module tb_patbuf_ctrl;

  localparam int DW = 8;
  localparam int BW = 3;
  localparam int FW = 5;

  logic          clk;
  logic          reset;
  logic [BW-1:0] core_bufp;
  logic [FW-1:0] core_fieldp, core_fieldwp;
  logic          core_wen;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_stall;
  logic [BW+FW-1:0] pb_rd_adr, pb_wr_adr;
  logic          pb_wen;
  logic [DW-1:0] pb_wdata, pb_rdata;
  logic          ld_start;
  logic [BW-1:0] ld_buf;
  logic [FW-1:0] ld_base;
  logic [FW:0]   ld_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready, ld_busy, ld_done, ld_err;
`ifdef PATBUF_LD_CSUM_EN
  logic [DW-1:0] ld_csum;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] a_adr [4] = '{8'h3E, 8'h3F, 8'h20, 8'h21};
  logic [2:0] b_buf [3] = '{3'd2, 3'd3, 3'd3};
  logic [5:0] b_len [3] = '{6'd4, 6'd0, 6'd33};

  patbuf_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .core_bufp    (core_bufp),
    .core_fieldp  (core_fieldp),
    .core_fieldwp (core_fieldwp),
    .core_wen     (core_wen),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .core_stall   (core_stall),
    .pb_rd_adr    (pb_rd_adr),
    .pb_wr_adr    (pb_wr_adr),
    .pb_wen       (pb_wen),
    .pb_wdata     (pb_wdata),
    .pb_rdata     (pb_rdata),
    .ld_start     (ld_start),
    .ld_buf       (ld_buf),
    .ld_base      (ld_base),
    .ld_len       (ld_len),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .ld_busy      (ld_busy),
    .ld_done      (ld_done),
    .ld_err       (ld_err)
`ifdef PATBUF_LD_CSUM_EN
    ,
    .ld_csum      (ld_csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; core_bufp = '0; core_fieldp = '0; core_fieldwp = '0;
    core_wen = 1'b0; core_wdata = '0; pb_rdata = '0; ld_start = 1'b0;
    ld_buf = '0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    tick(); tick();
    #1;
    chk("rst_busy",  32'(ld_busy), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_done",  32'(ld_done), 32'd0);
    chk("rst_err",   32'(ld_err), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_wen",   32'(pb_wen), 32'd0);
    reset = 1'b1;

    // Read path
    core_bufp = 3'd3; core_fieldp = 5'h11; pb_rdata = 8'h5A;
    #1;
    chk("rd_adr",  32'(pb_rd_adr), 32'h71);
    chk("rd_data", 32'(core_rdata), 32'h5A);
    core_bufp = 3'd0;

    // Wrapping burst: buf 1, base 30, len 4
    tick();
    ld_start = 1'b1; ld_buf = 3'd1; ld_base = 5'd30; ld_len = 6'd4;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 8'hA0 + 8'(i);
      #1;
      chk("a_busy",  32'(ld_busy), 32'd1);
      chk("a_wen",   32'(pb_wen), 32'd1);
      chk("a_adr",   32'(pb_wr_adr), 32'(a_adr[i]));
      chk("a_wdata", 32'(pb_wdata), 32'hA0 + 32'(i));
      chk("a_ready", 32'(ld_ready), 32'd1);
      chk("a_done0", 32'(ld_done), 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    #1;
    chk("a_done",   32'(ld_done), 32'd1);
    chk("a_idle",   32'(ld_busy), 32'd0);
    chk("a_wen_off", 32'(pb_wen), 32'd0);
    tick();
    chk("a_done_pulse", 32'(ld_done), 32'd0);

    // Rejected starts: same buffer as core, len 0, len 33
    core_bufp = 3'd2; ld_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_start = 1'b1; ld_buf = b_buf[k]; ld_base = 5'd0; ld_len = b_len[k];
      tick();
      ld_start = 1'b0;
      #1;
      chk("b_err",   32'(ld_err), 32'd1);
      chk("b_busy",  32'(ld_busy), 32'd0);
      chk("b_wen",   32'(pb_wen), 32'd0);
      chk("b_ready", 32'(ld_ready), 32'd0);
      tick();
      chk("b_err_pulse", 32'(ld_err), 32'd0);
      chk("b_busy2", 32'(ld_busy), 32'd0);
    end

    // Starvation: core writes every cycle, start during LOAD at cycle 2
    core_bufp = 3'd0; ld_valid = 1'b0;
    ld_start = 1'b1; ld_buf = 3'd5; ld_base = 5'd0; ld_len = 6'd2;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; core_wen = 1'b1;
    core_fieldwp = 5'd7; core_wdata = 8'h55;
    for (int c = 0; c < 10; c++) begin
      ld_data = 8'hC0 + 8'(c);
      if (c == 2) begin
        ld_start = 1'b1; ld_buf = 3'd6; ld_base = 5'd9; ld_len = 6'd1;
      end else begin
        ld_start = 1'b0;
      end
      #1;
      chk("c_wen",   32'(pb_wen), 32'd1);
      chk("c_adr",   32'(pb_wr_adr), (c % 5 == 4) ? ((c == 4) ? 32'hA0 : 32'hA1) : 32'h07);
      chk("c_wdata", 32'(pb_wdata), (c % 5 == 4) ? 32'hC0 + 32'(c) : 32'h55);
      chk("c_stall", 32'(core_stall), (c % 5 == 4) ? 32'd1 : 32'd0);
      chk("c_ready", 32'(ld_ready), (c % 5 == 4) ? 32'd1 : 32'd0);
      chk("c_err",   32'(ld_err), (c == 3) ? 32'd1 : 32'd0);
      chk("c_busy",  32'(ld_busy), 32'd1);
      tick();
    end
    #1;
    chk("c_done",  32'(ld_done), 32'd1);
    chk("c_idle",  32'(ld_busy), 32'd0);
    chk("c_pass_adr", 32'(pb_wr_adr), 32'h07);
    chk("c_pass_stall", 32'(core_stall), 32'd0);
    ld_valid = 1'b0; core_wen = 1'b0;

    // Reset mid-burst
    tick();
    ld_start = 1'b1; ld_buf = 3'd1; ld_base = 5'd0; ld_len = 6'd4;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'h11;
    #1;
    chk("d_wen_pre", 32'(pb_wen), 32'd1);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("d_busy",  32'(ld_busy), 32'd0);
    chk("d_ready", 32'(ld_ready), 32'd0);
    chk("d_wen",   32'(pb_wen), 32'd0);
    chk("d_stall", 32'(core_stall), 32'd0);
    chk("d_done",  32'(ld_done), 32'd0);
    chk("d_err",   32'(ld_err), 32'd0);
    reset = 1'b1;
    tick();
    chk("d_done_after", 32'(ld_done), 32'd0);
    chk("d_wen_after",  32'(pb_wen), 32'd0);
    tick();
    chk("d_done_after2", 32'(ld_done), 32'd0);
    chk("d_busy_after",  32'(ld_busy), 32'd0);
    ld_valid = 1'b0;

`ifdef PATBUF_LD_CSUM_EN
    // Checksum: F0 + 20 + 05 = 0x115 -> 0x15
    tick();
    ld_start = 1'b1; ld_buf = 3'd1; ld_base = 5'd0; ld_len = 6'd3;
    tick();
    chk("e_csum_clr", 32'(ld_csum), 32'd0);
    ld_start = 1'b0; ld_valid = 1'b1;
    ld_data = 8'hF0; tick();
    ld_data = 8'h20; tick();
    ld_data = 8'h05; tick();
    ld_valid = 1'b0;
    #1;
    chk("e_done", 32'(ld_done), 32'd1);
    chk("e_csum", 32'(ld_csum), 32'h15);
    tick();
    chk("e_csum_hold", 32'(ld_csum), 32'h15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
